// File: rtl/router_pkg.sv
// Shared types for the router input path: FSM state encoding, default channel count
// and the address-width helper used to size channel addresses.
package router_pkg;

  typedef enum logic [3:0] {
    StDa   = 4'd0,
    StLfd  = 4'd1,
    StLd   = 4'd2,
    StWte  = 4'd3,
    StCpe  = 4'd4,
    StLp   = 4'd5,
    StFfs  = 4'd6,
    StLaf  = 4'd7,
    StDrop = 4'd8
  } state_e;

  localparam int unsigned NumChDefault = 3;

  // A channel address is always at least one bit wide.
  function automatic int unsigned addr_width(int unsigned num_ch);
    return (num_ch > 2) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/router_fsm_nch_if.sv
// Handshake bundle between the input register/parity block, the channel FIFOs and the
// router input FSM. The slave modport is the FSM side.
interface router_fsm_nch_if #(
  parameter int unsigned NUM_CH = router_pkg::NumChDefault,
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned ADDR_W = router_pkg::addr_width(NUM_CH);

  logic              pkt_valid;
  logic [DATA_W-1:0] data_in;
  logic              fifo_full;
  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] soft_reset;
  logic              parity_done;
  logic              low_packet_valid;

  logic [ADDR_W-1:0] dest_addr;
  logic              write_enb_reg;
  logic              detect_add;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              rst_int_reg;
  logic              drop_state;
  logic              pkt_dropped;
  logic              busy;

  modport master (
    output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset, parity_done,
           low_packet_valid,
    input  dest_addr, write_enb_reg, detect_add, lfd_state, ld_state, laf_state,
           full_state, rst_int_reg, drop_state, pkt_dropped, busy
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset, parity_done,
           low_packet_valid,
    output dest_addr, write_enb_reg, detect_add, lfd_state, ld_state, laf_state,
           full_state, rst_int_reg, drop_state, pkt_dropped, busy
  );

endinterface

// File: rtl/router_addr_decode.sv
// Channel address decoder: one-hot channel select plus legality flag. Shared with the
// synchroniser so both agree on which addresses exist.
module router_addr_decode #(
  parameter int unsigned NumCh = 3,
  parameter int unsigned AddrW = 2
) (
  input  logic [AddrW-1:0] addr_i,
  output logic             legal_o,
  output logic [NumCh-1:0] sel_o
);

  always_comb begin
    sel_o = '0;
    for (int unsigned i = 0; i < NumCh; i++) begin
      sel_o[i] = (32'(addr_i) == i);
    end
  end

  // An address with no matching channel is out of range.
  assign legal_o = |sel_o;

endmodule

// File: rtl/router_fsm_nch.sv
// N-channel router input controller FSM with illegal-address drop path.
// Optional wait-till-empty timeout enabled by defining ROUTER_FSM_WTE_TIMEOUT_EN.
module router_fsm_nch
  import router_pkg::*;
#(
  parameter int unsigned NUM_CH      = NumChDefault,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WTE_TIMEOUT = 255
) (
  input logic             clock,
  input logic             resetn,
  router_fsm_nch_if.slave bus
);

  localparam int unsigned ADDR_W = addr_width(NUM_CH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] dest_addr_q, dest_addr_d;
  logic              pkt_dropped_q, pkt_dropped_d;
  logic [ADDR_W-1:0] hdr_addr;
  logic              hdr_legal, dest_legal;
  logic [NUM_CH-1:0] hdr_sel, dest_sel;
  logic              hdr_empty, dest_empty, dest_srst;
  logic              wte_expired;

  assign hdr_addr = bus.data_in[ADDR_W-1:0];

  router_addr_decode #(
    .NumCh (NUM_CH),
    .AddrW (ADDR_W)
  ) u_hdr_decode (
    .addr_i  (hdr_addr),
    .legal_o (hdr_legal),
    .sel_o   (hdr_sel)
  );

  router_addr_decode #(
    .NumCh (NUM_CH),
    .AddrW (ADDR_W)
  ) u_dest_decode (
    .addr_i  (dest_addr_q),
    .legal_o (dest_legal),
    .sel_o   (dest_sel)
  );

  assign hdr_empty  = |(bus.fifo_empty & hdr_sel);
  assign dest_empty = |(bus.fifo_empty & dest_sel);
  assign dest_srst  = |(bus.soft_reset & dest_sel);

  logic unused_bits;
  assign unused_bits = ^{bus.data_in[DATA_W-1:ADDR_W], dest_legal};

`ifdef ROUTER_FSM_WTE_TIMEOUT_EN
  localparam int unsigned CntRaw = $clog2(WTE_TIMEOUT + 1);
  localparam int unsigned CntW   = (CntRaw < 8) ? 8 : ((CntRaw > 16) ? 16 : CntRaw);

  logic [CntW-1:0] wte_cnt_q, wte_cnt_d;

  // Counter reads 0 on the first WTE cycle, so WTE lasts exactly WTE_TIMEOUT cycles.
  assign wte_expired = (wte_cnt_q == CntW'(WTE_TIMEOUT - 1));
  assign wte_cnt_d   = (state_q == StWte && state_d == StWte) ? wte_cnt_q + 1'b1 : '0;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wte_cnt_q <= '0;
    end else begin
      wte_cnt_q <= wte_cnt_d;
    end
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = WTE_TIMEOUT;
  assign wte_expired    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    dest_addr_d = dest_addr_q;
    unique case (state_q)
      StDa: begin
        if (bus.pkt_valid) begin
          dest_addr_d = hdr_addr;
          if (!hdr_legal)     state_d = StDrop;
          else if (hdr_empty) state_d = StLfd;
          else                state_d = StWte;
        end
      end
      StLfd: state_d = StLd;
      StLd: begin
        if (bus.fifo_full)       state_d = StFfs;
        else if (!bus.pkt_valid) state_d = StLp;
      end
      StFfs: if (!bus.fifo_full) state_d = StLaf;
      StLaf: begin
        if (bus.parity_done)           state_d = StDa;
        else if (bus.low_packet_valid) state_d = StLp;
        else                           state_d = StLd;
      end
      StLp:  state_d = StCpe;
      StCpe: state_d = bus.fifo_full ? StFfs : StDa;
      StWte: begin
        if (dest_empty)       state_d = StLfd;
        else if (wte_expired) state_d = StDrop;
      end
      StDrop: if (!bus.pkt_valid) state_d = StDa;
      default: state_d = StDa;
    endcase
    // Channel soft reset abandons the packet from any loading state.
    if (dest_srst && state_q != StDa && state_q != StDrop) begin
      state_d = StDa;
    end
  end

  assign pkt_dropped_d = (state_d == StDrop) && (state_q != StDrop);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q       <= StDa;
      dest_addr_q   <= '0;
      pkt_dropped_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      dest_addr_q   <= dest_addr_d;
      pkt_dropped_q <= pkt_dropped_d;
    end
  end

  assign bus.dest_addr     = dest_addr_q;
  assign bus.pkt_dropped   = pkt_dropped_q;
  assign bus.detect_add    = (state_q == StDa);
  assign bus.lfd_state     = (state_q == StLfd);
  assign bus.ld_state      = (state_q == StLd);
  assign bus.laf_state     = (state_q == StLaf);
  assign bus.full_state    = (state_q == StFfs);
  assign bus.rst_int_reg   = (state_q == StCpe);
  assign bus.drop_state    = (state_q == StDrop);
  assign bus.write_enb_reg = (state_q == StLd) || (state_q == StLp) || (state_q == StLaf);
  assign bus.busy          = !((state_q == StLd) || (state_q == StDa));

endmodule

// File: tb/tb_router_fsm_nch.sv
// Self-checking bench for router_fsm_nch (NUM_CH=3): vector table driven through a
// scoreboard queue, plus hand-written reset and timeout sequences.
module tb_router_fsm_nch;

  localparam int unsigned NumCh   = 3;
  localparam int unsigned DataW   = 8;
  localparam int unsigned Timeout = 4;

  typedef enum int {EDa, ELfd, ELd, EWte, ECpe, ELp, EFfs, ELaf, EDrop} exp_state_e;

  typedef struct {
    string      name;
    logic       rstn;
    logic       pv;
    logic [7:0] din;
    logic       full;
    logic [2:0] empty;
    logic [2:0] srst;
    logic       pd;
    logic       lpv;
    exp_state_e st;
    logic [1:0] dest;
    logic       dropped;
  } vec_t;

  typedef struct {
    string      name;
    logic [9:0] flags;
    logic [1:0] dest;
  } exp_t;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  router_fsm_nch_if #(.NUM_CH(NumCh), .DATA_W(DataW)) bus ();

  router_fsm_nch #(
    .NUM_CH      (NumCh),
    .DATA_W      (DataW),
    .WTE_TIMEOUT (Timeout)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  vec_t vecs[$];

  // Flag order: detect_add, lfd, ld, laf, full, rst_int, drop, write_enb, busy, pkt_dropped
  function automatic logic [9:0] flags_of(exp_state_e s, logic dropped);
    logic [9:0] f;
    f = '0;
    case (s)
      EDa:   f[9] = 1'b1;
      ELfd:  begin f[8] = 1'b1; f[1] = 1'b1; end
      ELd:   begin f[7] = 1'b1; f[2] = 1'b1; end
      ELaf:  begin f[6] = 1'b1; f[2] = 1'b1; f[1] = 1'b1; end
      EFfs:  begin f[5] = 1'b1; f[1] = 1'b1; end
      ECpe:  begin f[4] = 1'b1; f[1] = 1'b1; end
      EDrop: begin f[3] = 1'b1; f[1] = 1'b1; end
      ELp:   begin f[2] = 1'b1; f[1] = 1'b1; end
      EWte:  f[1] = 1'b1;
      default: f = '0;
    endcase
    f[0] = dropped;
    return f;
  endfunction

  function automatic vec_t mk(string name, logic rstn, logic pv, logic [7:0] din,
                              logic full, logic [2:0] empty, logic [2:0] srst, logic pd,
                              logic lpv, exp_state_e st, logic [1:0] dest, logic dropped);
    vec_t v;
    v.name = name; v.rstn = rstn; v.pv = pv; v.din = din; v.full = full;
    v.empty = empty; v.srst = srst; v.pd = pd; v.lpv = lpv;
    v.st = st; v.dest = dest; v.dropped = dropped;
    return v;
  endfunction

  task automatic check_out();
    exp_t       e;
    logic [9:0] got;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: output with no expectation queued");
      return;
    end
    e   = sb.pop_front();
    got = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state, bus.full_state,
           bus.rst_int_reg, bus.drop_state, bus.write_enb_reg, bus.busy, bus.pkt_dropped};
    if (got !== e.flags || bus.dest_addr !== e.dest) begin
      errors++;
      $display("FAIL %s: got flags=%b dest=%0d, expected flags=%b dest=%0d",
               e.name, got, bus.dest_addr, e.flags, e.dest);
    end
  endtask

  task automatic apply(vec_t v);
    exp_t e;
    @(negedge clock);
    resetn               = v.rstn;
    bus.pkt_valid        = v.pv;
    bus.data_in          = v.din;
    bus.fifo_full        = v.full;
    bus.fifo_empty       = v.empty;
    bus.soft_reset       = v.srst;
    bus.parity_done      = v.pd;
    bus.low_packet_valid = v.lpv;
    e.name  = v.name;
    e.flags = flags_of(v.st, v.dropped);
    e.dest  = v.dest;
    sb.push_back(e);
    @(posedge clock);
    #1;
    check_out();
  endtask

  initial begin
    bus.pkt_valid = 1'b0; bus.data_in = '0; bus.fifo_full = 1'b0;
    bus.fifo_empty = '1; bus.soft_reset = '0; bus.parity_done = 1'b0;
    bus.low_packet_valid = 1'b0;

    //                 name        rn pv din   fl empty   srst    pd lp  state  dst drop
    vecs.push_back(mk("rst0",      0, 0, 8'h00, 0, 3'b111, 3'b000, 0, 0, EDa,   0, 0));
    vecs.push_back(mk("rst1",      0, 1, 8'h01, 0, 3'b111, 3'b000, 0, 0, EDa,   0, 0));
    vecs.push_back(mk("idle",      1, 0, 8'h01, 0, 3'b111, 3'b000, 0, 0, EDa,   0, 0));
    vecs.push_back(mk("sp_hdr",    1, 1, 8'h01, 0, 3'b010, 3'b000, 0, 0, ELfd,  1, 0));
    vecs.push_back(mk("sp_lfd",    1, 1, 8'hAA, 0, 3'b010, 3'b000, 0, 0, ELd,   1, 0));
    vecs.push_back(mk("sp_ld",     1, 1, 8'hBB, 0, 3'b010, 3'b000, 0, 0, ELd,   1, 0));
    vecs.push_back(mk("sp_end",    1, 0, 8'h00, 0, 3'b010, 3'b000, 0, 0, ELp,   1, 0));
    vecs.push_back(mk("sp_lp",     1, 0, 8'h00, 0, 3'b010, 3'b000, 0, 0, ECpe,  1, 0));
    vecs.push_back(mk("sp_cpe",    1, 0, 8'h00, 0, 3'b010, 3'b000, 0, 0, EDa,   1, 0));
    vecs.push_back(mk("ff_hdr",    1, 1, 8'h00, 0, 3'b111, 3'b000, 0, 0, ELfd,  0, 0));
    vecs.push_back(mk("ff_lfd",    1, 1, 8'h11, 0, 3'b111, 3'b000, 0, 0, ELd,   0, 0));
    vecs.push_back(mk("ff_full1",  1, 1, 8'h22, 1, 3'b111, 3'b000, 0, 0, EFfs,  0, 0));
    vecs.push_back(mk("ff_full2",  1, 1, 8'h22, 1, 3'b111, 3'b000, 0, 0, EFfs,  0, 0));
    vecs.push_back(mk("ff_full3",  1, 1, 8'h22, 1, 3'b111, 3'b000, 0, 0, EFfs,  0, 0));
    vecs.push_back(mk("ff_rel",    1, 1, 8'h22, 0, 3'b111, 3'b000, 0, 0, ELaf,  0, 0));
    vecs.push_back(mk("ff_laf_lp", 1, 0, 8'h00, 0, 3'b111, 3'b000, 0, 1, ELp,   0, 0));
    vecs.push_back(mk("ff_lp",     1, 0, 8'h00, 0, 3'b111, 3'b000, 0, 0, ECpe,  0, 0));
    vecs.push_back(mk("ff_cpe",    1, 0, 8'h00, 0, 3'b111, 3'b000, 0, 0, EDa,   0, 0));
    vecs.push_back(mk("lf_hdr",    1, 1, 8'h00, 0, 3'b111, 3'b000, 0, 0, ELfd,  0, 0));
    vecs.push_back(mk("lf_lfd",    1, 1, 8'h33, 0, 3'b111, 3'b000, 0, 0, ELd,   0, 0));
    vecs.push_back(mk("lf_full",   1, 1, 8'h33, 1, 3'b111, 3'b000, 0, 0, EFfs,  0, 0));
    vecs.push_back(mk("lf_rel",    1, 1, 8'h33, 0, 3'b111, 3'b000, 0, 0, ELaf,  0, 0));
    vecs.push_back(mk("lf_laf_ld", 1, 1, 8'h33, 0, 3'b111, 3'b000, 0, 0, ELd,   0, 0));
    vecs.push_back(mk("lf_end",    1, 0, 8'h00, 0, 3'b111, 3'b000, 0, 0, ELp,   0, 0));
    vecs.push_back(mk("lf_lp",     1, 0, 8'h00, 0, 3'b111, 3'b000, 0, 0, ECpe,  0, 0));
    vecs.push_back(mk("lf_cpe_ff", 1, 0, 8'h00, 1, 3'b111, 3'b000, 0, 0, EFfs,  0, 0));
    vecs.push_back(mk("lf_rel2",   1, 0, 8'h00, 0, 3'b111, 3'b000, 0, 0, ELaf,  0, 0));
    vecs.push_back(mk("lf_par",    1, 0, 8'h00, 0, 3'b111, 3'b000, 1, 0, EDa,   0, 0));
    vecs.push_back(mk("wt_hdr",    1, 1, 8'h02, 0, 3'b011, 3'b000, 0, 0, EWte,  2, 0));
    vecs.push_back(mk("wt_hold1",  1, 1, 8'h44, 0, 3'b011, 3'b000, 0, 0, EWte,  2, 0));
    vecs.push_back(mk("wt_hold2",  1, 1, 8'h44, 0, 3'b011, 3'b000, 0, 0, EWte,  2, 0));
    vecs.push_back(mk("wt_empty",  1, 1, 8'h44, 0, 3'b111, 3'b000, 0, 0, ELfd,  2, 0));
    vecs.push_back(mk("wt_lfd",    1, 1, 8'h44, 0, 3'b111, 3'b000, 0, 0, ELd,   2, 0));
    vecs.push_back(mk("wt_end",    1, 0, 8'h00, 0, 3'b111, 3'b000, 0, 0, ELp,   2, 0));
    vecs.push_back(mk("wt_lp",     1, 0, 8'h00, 0, 3'b111, 3'b000, 0, 0, ECpe,  2, 0));
    vecs.push_back(mk("wt_cpe",    1, 0, 8'h00, 0, 3'b111, 3'b000, 0, 0, EDa,   2, 0));
    vecs.push_back(mk("dr_hdr",    1, 1, 8'h03, 0, 3'b111, 3'b000, 0, 0, EDrop, 3, 1));
    vecs.push_back(mk("dr_hold",   1, 1, 8'h55, 0, 3'b111, 3'b000, 0, 0, EDrop, 3, 0));
    vecs.push_back(mk("dr_srst",   1, 1, 8'h55, 0, 3'b111, 3'b111, 0, 0, EDrop, 3, 0));
    vecs.push_back(mk("dr_end",    1, 0, 8'h00, 0, 3'b111, 3'b000, 0, 0, EDa,   3, 0));
    vecs.push_back(mk("dr_idle",   1, 0, 8'h01, 0, 3'b111, 3'b111, 0, 0, EDa,   3, 0));
    vecs.push_back(mk("sr_hdr",    1, 1, 8'h01, 0, 3'b111, 3'b000, 0, 0, ELfd,  1, 0));
    vecs.push_back(mk("sr_lfd",    1, 1, 8'h66, 0, 3'b111, 3'b000, 0, 0, ELd,   1, 0));
    vecs.push_back(mk("sr_other",  1, 1, 8'h66, 0, 3'b111, 3'b100, 0, 0, ELd,   1, 0));
    vecs.push_back(mk("sr_hit",    1, 1, 8'h66, 0, 3'b111, 3'b010, 0, 0, EDa,   1, 0));
    vecs.push_back(mk("sr_idle",   1, 0, 8'h00, 0, 3'b111, 3'b000, 0, 0, EDa,   1, 0));
    vecs.push_back(mk("sw_hdr",    1, 1, 8'h02, 0, 3'b011, 3'b000, 0, 0, EWte,  2, 0));
    vecs.push_back(mk("sw_hit",    1, 1, 8'h77, 0, 3'b011, 3'b100, 0, 0, EDa,   2, 0));
    vecs.push_back(mk("sw_idle",   1, 0, 8'h00, 0, 3'b111, 3'b000, 0, 0, EDa,   2, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
    end

    // Reset taken mid-packet while stalled on a full FIFO.
    apply(mk("rm_hdr",   1, 1, 8'h01, 0, 3'b111, 3'b000, 0, 0, ELfd, 1, 0));
    apply(mk("rm_lfd",   1, 1, 8'h88, 0, 3'b111, 3'b000, 0, 0, ELd,  1, 0));
    apply(mk("rm_full",  1, 1, 8'h88, 1, 3'b111, 3'b000, 0, 0, EFfs, 1, 0));
    apply(mk("rm_reset", 0, 1, 8'h88, 1, 3'b111, 3'b000, 0, 0, EDa,  0, 0));
    apply(mk("rm_after", 1, 0, 8'h00, 0, 3'b111, 3'b000, 0, 0, EDa,  0, 0));

`ifdef ROUTER_FSM_WTE_TIMEOUT_EN
    // Target never drains: WTE lasts Timeout cycles, then the packet is dropped.
    apply(mk("to_hdr",   1, 1, 8'h02, 0, 3'b011, 3'b000, 0, 0, EWte,  2, 0));
    for (int i = 1; i < Timeout; i++) begin
      apply(mk("to_wait", 1, 1, 8'h99, 0, 3'b011, 3'b000, 0, 0, EWte, 2, 0));
    end
    apply(mk("to_drop",  1, 1, 8'h99, 0, 3'b011, 3'b000, 0, 0, EDrop, 2, 1));
    apply(mk("to_hold",  1, 1, 8'h99, 0, 3'b011, 3'b000, 0, 0, EDrop, 2, 0));
    apply(mk("to_end",   1, 0, 8'h00, 0, 3'b011, 3'b000, 0, 0, EDa,   2, 0));
`endif

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/router_fsm_nch.md
Name: router_fsm_nch

Overview:
Parametrised successor to the 1xN router input controller FSM.
- Decodes the header byte and latches the destination channel.
- Sequences first-data, payload, parity and full/after-full loading into the selected channel FIFO.
- Generalised to NUM_CH output channels with vector empty/soft-reset inputs.
- Adds an illegal-address drop path that the 3-channel controller lacks.
- Sits between the input register/parity block and the per-channel FIFOs plus synchroniser.

Parameters:
NUM_CH, 3, number of output channels/FIFOs (2..16)
DATA_W, 8, width of data_in; header address in data_in[ADDR_W-1:0]
ADDR_W, $clog2(NUM_CH) (min 1), derived localparam, not overridable
WTE_TIMEOUT, 255, wait-till-empty timeout in cycles (used only with the optional feature)

Ports:
clock  in  1  single system clock, rising edge
resetn  in  1  synchronous active-low reset
pkt_valid  in  1  packet valid from source
data_in  in  DATA_W  input byte; header carries destination address
fifo_full  in  1  full flag of currently addressed FIFO (muxed externally)
fifo_empty  in  NUM_CH  per-channel FIFO empty flags
soft_reset  in  NUM_CH  per-channel soft reset from synchroniser
parity_done  in  1  parity byte captured
low_packet_valid  in  1  pkt_valid fell while FIFO full
dest_addr  out  ADDR_W  latched destination channel
write_enb_reg  out  1  write enable to input register path
detect_add  out  1  in DA
lfd_state  out  1  in LFD
ld_state  out  1  in LD
laf_state  out  1  in LAF
full_state  out  1  in FFS
rst_int_reg  out  1  in CPE
drop_state  out  1  in DROP
pkt_dropped  out  1  one-cycle pulse when a packet is discarded
busy  out  1  backpressure to source

Behaviour:
- Reset (resetn=0 at posedge): state=DA, dest_addr=0, pkt_dropped=0, timeout counter=0.
- Outputs after reset: detect_add=1, all other outputs 0.
- States (4-bit encoding): DA, LFD, LD, WTE, CPE, LP, FFS, LAF, DROP.
- DA: on pkt_valid, latch addr=data_in[ADDR_W-1:0] into dest_addr.
  - addr>=NUM_CH -> DROP, pulse pkt_dropped.
  - else fifo_empty[addr]=1 -> LFD.
  - else -> WTE.
  - no pkt_valid -> stay; dest_addr holds.
- LFD: -> LD unconditionally.
- LD: fifo_full -> FFS; else !pkt_valid -> LP; else stay.
- FFS: stay while fifo_full; else -> LAF.
- LAF: parity_done -> DA; else low_packet_valid -> LP; else -> LD.
- LP: -> CPE.
- CPE: fifo_full -> FFS; else -> DA.
- WTE: fifo_empty[dest_addr] -> LFD; else stay.
- DROP: stay while pkt_valid; -> DA when pkt_valid=0. No FIFO writes in DROP.
- Soft reset: in LFD/LD/WTE/CPE/LP/FFS/LAF, soft_reset[dest_addr]=1 -> DA next cycle. It overrides all other transitions. Ignored in DA and DROP.
- Outputs are Moore and combinational from state:
  - write_enb_reg = LD|LP|LAF
  - busy = LFD|LP|FFS|LAF|WTE|CPE|DROP (LD and DA not busy)
  - rst_int_reg = CPE
  - each *_state flag = its own state
- dest_addr stays stable from DA exit until the next DA capture.

Optional Feature:
ROUTER_FSM_WTE_TIMEOUT_EN
- Defined: an 8..16-bit counter clears on WTE entry and increments each WTE cycle. When it reaches WTE_TIMEOUT with fifo_empty[dest_addr] still 0: go to DROP and pulse pkt_dropped. The counter resets on WTE exit.
- Undefined: WTE waits indefinitely; no counter logic.

Decomposition:
- Shared package router_pkg holds:
  - state enum/localparams (4-bit)
  - NUM_CH default
  - ADDR_W derivation function
- One sub-module, router_addr_decode: combinational legality check plus one-hot channel select from the address. It is reused by the synchroniser.
- The FSM itself stays flat.

Test Plan:
- Short packet, NUM_CH=3: pkt_valid=1, data_in=8'h01, fifo_empty=3'b010 -> DA,LFD,LD. Drop pkt_valid -> LP,CPE,DA; dest_addr=1; write_enb_reg high in LD/LP only.
- FIFO full mid-payload: in LD assert fifo_full for 3 cycles -> FFS x3, LAF. Then low_packet_valid=1, parity_done=0 -> LP,CPE,DA; busy=1 throughout FFS/LAF.
- Non-empty target: data_in=8'h02, fifo_empty=3'b011 -> WTE held. fifo_empty[2]=1 -> LFD next cycle.
- Illegal address: NUM_CH=3, data_in=8'h03 -> DROP. pkt_dropped pulses once; write_enb_reg=0. Return to DA one cycle after pkt_valid=0.
- Soft reset: in LD with dest_addr=1, pulse soft_reset=3'b010 -> DA next cycle. soft_reset=3'b100 instead -> no effect.
- Reset mid-packet: resetn=0 in FFS -> DA at next edge, all outputs at reset values. With ROUTER_FSM_WTE_TIMEOUT_EN and WTE_TIMEOUT=4: WTE entry then DROP after 4 cycles.
